core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
Round-robin arbiter that shares the single inter-core command bus between NUM_CORES requesters. It sits between the AXI interrupt controller's per-core send interface (send_req/broadcast_mode/dst_ids/instructions/send_grant) and the bus transmit port. Single-cycle request pulses are latched as pending commands. One command at a time is driven onto the bus with a valid/ready handshake.

Parameters:
- NUM_CORES, 4, number of requesters/cores; must be >= 2.
- INSTR_WIDTH, 2, bus instruction width (00 HALT_PAUSE, 01 STOP, 10 CONTINUE, 11 DONE).
- TIMEOUT_CYCLES, 256, XFER stall limit; used only with ARB_TIMEOUT_EN.
- Derived: ID_W = $clog2(NUM_CORES).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- send_req  in  NUM_CORES  per-core request pulse; samples that core's command fields.
- broadcast_mode  in  NUM_CORES  per-core broadcast flag.
- dst_ids  in  NUM_CORES*ID_W  per-core destination; slice i at [i*ID_W +: ID_W].
- instructions  in  NUM_CORES*INSTR_WIDTH  per-core instruction; slice i at [i*INSTR_WIDTH +: INSTR_WIDTH].
- send_grant  out  NUM_CORES  one-cycle one-hot pulse when core i's command is launched.
- bus_valid  out  1  command on bus is valid.
- bus_ready  in  1  bus accepts command (transfer when bus_valid && bus_ready).
- bus_src_id  out  ID_W  granted core index.
- bus_dst_id  out  ID_W  captured destination.
- bus_broadcast  out  1  captured broadcast flag.
- bus_instr  out  INSTR_WIDTH  captured instruction.
- req_overwrite  out  1  pulse: a pending, not-yet-granted command was replaced.
- bus_timeout  out  1  pulse: transfer abandoned (0 when macro absent).
- busy  out  1  high in XFER or when any command is pending.

Behaviour:
- Reset (async, resetn=0): all outputs 0; pending bits and stored commands cleared; FSM = IDLE; rr_last = NUM_CORES-1, so core 0 has highest priority first.
- Pending capture: a send_req[i] sampled high sets pending[i] and stores core i's broadcast, dst and instr slices.
  - If pending[i] is already set: the new command overwrites the stored one and req_overwrite pulses the next cycle.
- FSM IDLE:
  - If any pending bit is set at the edge, select the first pending index scanning rr_last+1, rr_last+2, ... modulo NUM_CORES.
  - Register bus_* from that core's stored command; set bus_valid=1; pulse send_grant[sel] for one cycle; clear pending[sel]; rr_last <= sel; go to XFER.
- FSM XFER:
  - bus_valid and all bus_* fields are held stable until handshake.
  - On bus_valid && bus_ready: bus_valid <= 0 and go to IDLE. Throughput is at most one command per 2 cycles.
  - No other grant occurs while in XFER. New requests are only latched.
- Latency: send_req high at edge E0 → pending after E0 → send_grant/bus_valid high after E1 when the bus is idle and no other core wins.
- Simultaneous set/clear: if send_req[i] arrives on the same edge core i is granted, the granted command goes out and pending[i] stays set with the new command. No overwrite pulse.
- Broadcast: bus_dst_id is driven with the stored value unchanged; interpretation is left to the bus.
- Reset mid-XFER: bus_valid drops immediately; the in-flight command is lost; no grant until a new send_req.
- Outputs are registered. No combinational path from bus_ready to any output.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering XFER and increments each XFER cycle without bus_ready.
  - When it reaches TIMEOUT_CYCLES: bus_valid <= 0, bus_timeout pulses for 1 cycle, FSM returns to IDLE, and the command is dropped.
  - A handshake in the same cycle as the limit counts as success; no timeout.
- ARB_TIMEOUT_EN undefined: XFER waits indefinitely; bus_timeout is tied 0; no counter is present.

Test Plan:
- Single request: send_req=0100, dst slice2=1, instr slice2=10, bus_ready=1 → send_grant=0100 one cycle 2 edges later; bus_src_id=2, bus_dst_id=1, bus_instr=10; bus_valid high for 1 cycle.
- Fairness: send_req=1111 in one cycle, bus_ready=1 → grants 0,1,2,3 every 2 cycles. A second 1111 then grants 0 first again, since rr_last=3.
- Stall: grant core1, bus_ready=0 for 5 cycles while core3 requests → bus_* stable for 5 cycles, no grant to core3 until 1 cycle after the handshake.
- Overwrite: core1 in XFER; core2 requests instr=00, then instr=01 → req_overwrite pulses once; exactly one core2 transfer with bus_instr=01.
- Reset mid-transfer: assert resetn=0 during XFER → bus_valid, send_grant and busy go 0 immediately; after release, no bus_valid without a new send_req.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): bus_ready=0 → bus_timeout pulses after 8 XFER cycles; bus_valid low; the pending next core is granted in the following cycle.

Source files
------------

// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - Request/grant and command-bus signal bundle for core_bus_arbiter
//
// Purpose: groups the per-core send interface and the bus transmit port.
// Modports:
//   master - arbiter side: samples send_req/broadcast_mode/dst_ids/instructions/bus_ready,
//            drives send_grant, bus_valid, bus_src_id, bus_dst_id, bus_broadcast,
//            bus_instr, req_overwrite, bus_timeout, busy.
//   slave  - requester/bus side: the mirror image of master.

interface core_bus_arbiter_if #(
    parameter int NUM_CORES   = 4,
    parameter int INSTR_WIDTH = 2
);
    localparam int ID_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]             send_req;
    logic [NUM_CORES-1:0]             broadcast_mode;
    logic [NUM_CORES*ID_W-1:0]        dst_ids;
    logic [NUM_CORES*INSTR_WIDTH-1:0] instructions;
    logic [NUM_CORES-1:0]             send_grant;

    logic                             bus_valid;
    logic                             bus_ready;
    logic [ID_W-1:0]                  bus_src_id;
    logic [ID_W-1:0]                  bus_dst_id;
    logic                             bus_broadcast;
    logic [INSTR_WIDTH-1:0]           bus_instr;

    logic                             req_overwrite;
    logic                             bus_timeout;
    logic                             busy;

    modport master (
        input  send_req, broadcast_mode, dst_ids, instructions, bus_ready,
        output send_grant, bus_valid, bus_src_id, bus_dst_id, bus_broadcast,
               bus_instr, req_overwrite, bus_timeout, busy
    );

    modport slave (
        output send_req, broadcast_mode, dst_ids, instructions, bus_ready,
        input  send_grant, bus_valid, bus_src_id, bus_dst_id, bus_broadcast,
               bus_instr, req_overwrite, bus_timeout, busy
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - Round-robin arbiter for the shared inter-core command bus
//
// Purpose: latches single-cycle per-core send requests as pending commands and
// launches one at a time onto the bus with a valid/ready handshake, rotating
// priority starting after the most recently granted core.
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset
//   bus_if  - core_bus_arbiter_if.master (send_req/broadcast_mode/dst_ids/
//             instructions in, send_grant out, bus_* command port,
//             req_overwrite/bus_timeout/busy status pulses and level)
// Optional feature macro: ARB_TIMEOUT_EN - abandons a transfer after
//   TIMEOUT_CYCLES stalled XFER cycles and pulses bus_timeout.

module core_bus_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int INSTR_WIDTH    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               resetn,
    core_bus_arbiter_if.master bus_if
);
    localparam int ID_W = $clog2(NUM_CORES);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                 state;
    logic [NUM_CORES-1:0]   pending;
    logic [NUM_CORES-1:0]   cmd_bcast;
    logic [ID_W-1:0]        cmd_dst   [NUM_CORES];
    logic [INSTR_WIDTH-1:0] cmd_instr [NUM_CORES];
    logic [ID_W-1:0]        rr_last;

    logic                   found;
    logic [ID_W-1:0]        sel_idx;
    logic [ID_W-1:0]        scan_sel;
    int                     scan_idx;
    logic [NUM_CORES-1:0]   grant_vec;
    logic [NUM_CORES-1:0]   pending_nxt;
    logic                   tmo_hit;
    logic                   xfer_nxt;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // Rotating scan: first pending core at rr_last+1, rr_last+2, ... mod NUM_CORES.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        scan_idx = 0;
        scan_sel = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            scan_idx = (int'(rr_last) + k) % NUM_CORES;
            scan_sel = ID_W'(scan_idx);
            if (!found && pending[scan_sel]) begin
                found   = 1'b1;
                sel_idx = scan_sel;
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (state == IDLE && found) begin
            grant_vec = NUM_CORES'(1) << sel_idx;
        end
        // A request on the granting edge re-arms the bit with the new command.
        pending_nxt = (pending & ~grant_vec) | bus_if.send_req;
`ifdef ARB_TIMEOUT_EN
        tmo_hit = (state == XFER) && !bus_if.bus_ready &&
                  (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
        tmo_hit = 1'b0;
`endif
        if (state == IDLE) begin
            xfer_nxt = found;
        end else begin
            xfer_nxt = !(bus_if.bus_ready || tmo_hit);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                <= IDLE;
            pending              <= '0;
            cmd_bcast            <= '0;
            rr_last              <= ID_W'(NUM_CORES - 1);
            bus_if.send_grant    <= '0;
            bus_if.bus_valid     <= 1'b0;
            bus_if.bus_src_id    <= '0;
            bus_if.bus_dst_id    <= '0;
            bus_if.bus_broadcast <= 1'b0;
            bus_if.bus_instr     <= '0;
            bus_if.req_overwrite <= 1'b0;
            bus_if.bus_timeout   <= 1'b0;
            bus_if.busy          <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cmd_dst[i]   <= '0;
                cmd_instr[i] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            tmo_cnt              <= '0;
`endif
        end else begin
            bus_if.send_grant    <= grant_vec;
            // Replacing a command that is being granted this edge is not an overwrite.
            bus_if.req_overwrite <= |(bus_if.send_req & pending & ~grant_vec);
            bus_if.busy          <= xfer_nxt || (|pending_nxt);
            bus_if.bus_timeout   <= tmo_hit;
            pending              <= pending_nxt;

            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus_if.send_req[i]) begin
                    cmd_bcast[i] <= bus_if.broadcast_mode[i];
                    cmd_dst[i]   <= bus_if.dst_ids[i*ID_W +: ID_W];
                    cmd_instr[i] <= bus_if.instructions[i*INSTR_WIDTH +: INSTR_WIDTH];
                end
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        bus_if.bus_valid     <= 1'b1;
                        bus_if.bus_src_id    <= sel_idx;
                        bus_if.bus_dst_id    <= cmd_dst[sel_idx];
                        bus_if.bus_broadcast <= cmd_bcast[sel_idx];
                        bus_if.bus_instr     <= cmd_instr[sel_idx];
                        rr_last              <= sel_idx;
                        state                <= XFER;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt              <= '0;
`endif
                    end
                end
                XFER: begin
                    // Handshake wins over a timeout landing on the same edge.
                    if (bus_if.bus_ready) begin
                        bus_if.bus_valid <= 1'b0;
                        state            <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        bus_if.bus_valid <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - Directed self-checking bench for core_bus_arbiter

module tb_core_bus_arbiter;
    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    core_bus_arbiter_if #(.NUM_CORES(4), .INSTR_WIDTH(2)) bif ();

    core_bus_arbiter #(
        .NUM_CORES(4),
        .INSTR_WIDTH(2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus_if(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int core, input logic bc, input logic [1:0] dst,
                           input logic [1:0] instr);
        bif.broadcast_mode[core]      = bc;
        bif.dst_ids[core*2 +: 2]      = dst;
        bif.instructions[core*2 +: 2] = instr;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        bif.send_req  = '0;
        bif.bus_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks             = 0;
        failures           = 0;
        resetn             = 1'b0;
        bif.send_req       = '0;
        bif.broadcast_mode = '0;
        bif.dst_ids        = '0;
        bif.instructions   = '0;
        bif.bus_ready      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(bif.bus_valid), 0);
        check("rst_grant", 32'(bif.send_grant), 0);
        check("rst_busy", 32'(bif.busy), 0);
        check("rst_ovw", 32'(bif.req_overwrite), 0);
        check("rst_tmo", 32'(bif.bus_timeout), 0);
        check("rst_src", 32'(bif.bus_src_id), 0);
        check("rst_instr", 32'(bif.bus_instr), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Single request from core 2
        set_cmd(2, 1'b0, 2'd1, 2'b10);
        bif.send_req  = 4'b0100;
        bif.bus_ready = 1'b1;
        @(negedge clk);
        bif.send_req = '0;
        check("single_nogrant_yet", 32'(bif.send_grant), 0);
        check("single_busy_pending", 32'(bif.busy), 1);
        @(negedge clk);
        check("single_grant", 32'(bif.send_grant), 32'b0100);
        check("single_valid", 32'(bif.bus_valid), 1);
        check("single_src", 32'(bif.bus_src_id), 2);
        check("single_dst", 32'(bif.bus_dst_id), 1);
        check("single_instr", 32'(bif.bus_instr), 2);
        check("single_bcast", 32'(bif.bus_broadcast), 0);
        @(negedge clk);
        check("single_valid_drop", 32'(bif.bus_valid), 0);
        check("single_grant_drop", 32'(bif.send_grant), 0);
        check("single_idle", 32'(bif.busy), 0);

        // Fairness: all four at once, from reset priority
        do_reset();
        bif.bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_cmd(i, i[0], 2'(3 - i), 2'(i));
        bif.send_req = 4'b1111;
        @(negedge clk);
        bif.send_req = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("fair_grant%0d", k), 32'(bif.send_grant), 32'(1) << k);
            check($sformatf("fair_src%0d", k), 32'(bif.bus_src_id), 32'(k));
            check($sformatf("fair_dst%0d", k), 32'(bif.bus_dst_id), 32'(3 - k));
            check($sformatf("fair_instr%0d", k), 32'(bif.bus_instr), 32'(k));
            check($sformatf("fair_bcast%0d", k), 32'(bif.bus_broadcast), 32'(k & 1));
            @(negedge clk);
            check($sformatf("fair_gap_grant%0d", k), 32'(bif.send_grant), 0);
            check($sformatf("fair_gap_valid%0d", k), 32'(bif.bus_valid), 0);
        end
        bif.send_req = 4'b1111;
        @(negedge clk);
        bif.send_req = '0;
        @(negedge clk);
        check("fair_round2_first", 32'(bif.send_grant), 32'b0001);

        // Stall: core 1 held off by bus_ready=0 while core 3 waits
        do_reset();
        set_cmd(1, 1'b0, 2'd3, 2'b01);
        set_cmd(3, 1'b1, 2'd0, 2'b11);
        bif.send_req = 4'b0010;
        @(negedge clk);
        bif.send_req = 4'b1000;
        @(negedge clk);
        bif.send_req = '0;
        check("stall_grant1", 32'(bif.send_grant), 32'b0010);
        check("stall_valid", 32'(bif.bus_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall_hold_valid%0d", c), 32'(bif.bus_valid), 1);
            check($sformatf("stall_hold_src%0d", c), 32'(bif.bus_src_id), 1);
            check($sformatf("stall_hold_dst%0d", c), 32'(bif.bus_dst_id), 3);
            check($sformatf("stall_hold_instr%0d", c), 32'(bif.bus_instr), 1);
            check($sformatf("stall_no_grant%0d", c), 32'(bif.send_grant), 0);
        end
        bif.bus_ready = 1'b1;
        @(negedge clk);
        check("stall_hs_valid", 32'(bif.bus_valid), 0);
        check("stall_hs_grant", 32'(bif.send_grant), 0);
        @(negedge clk);
        check("stall_grant3", 32'(bif.send_grant), 32'b1000);
        check("stall_src3", 32'(bif.bus_src_id), 3);
        check("stall_dst3", 32'(bif.bus_dst_id), 0);
        check("stall_instr3", 32'(bif.bus_instr), 3);
        check("stall_bcast3", 32'(bif.bus_broadcast), 1);
        @(negedge clk);
        check("stall_end_valid", 32'(bif.bus_valid), 0);
        check("stall_end_busy", 32'(bif.busy), 0);

        // Overwrite of a pending core 2 command while core 1 is in XFER
        do_reset();
        set_cmd(1, 1'b0, 2'd0, 2'b10);
        bif.send_req = 4'b0010;
        @(negedge clk);
        bif.send_req = '0;
        @(negedge clk);
        check("ovw_xfer_src", 32'(bif.bus_src_id), 1);
        set_cmd(2, 1'b0, 2'd2, 2'b00);
        bif.send_req = 4'b0100;
        @(negedge clk);
        check("ovw_first_none", 32'(bif.req_overwrite), 0);
        set_cmd(2, 1'b0, 2'd2, 2'b01);
        @(negedge clk);
        bif.send_req = '0;
        check("ovw_pulse", 32'(bif.req_overwrite), 1);
        @(negedge clk);
        check("ovw_pulse_end", 32'(bif.req_overwrite), 0);
        bif.bus_ready = 1'b1;
        @(negedge clk);
        check("ovw_hs1", 32'(bif.bus_valid), 0);
        @(negedge clk);
        check("ovw_grant2", 32'(bif.send_grant), 32'b0100);
        check("ovw_instr", 32'(bif.bus_instr), 1);
        check("ovw_dst", 32'(bif.bus_dst_id), 2);
        @(negedge clk);
        check("ovw_done_valid", 32'(bif.bus_valid), 0);
        check("ovw_done_busy", 32'(bif.busy), 0);
        @(negedge clk);
        check("ovw_single_xfer", 32'(bif.send_grant), 0);

        // Request arriving on the edge that grants the same core
        do_reset();
        set_cmd(0, 1'b0, 2'd1, 2'b10);
        bif.send_req = 4'b0001;
        @(negedge clk);
        check("simul_no_ovw_e0", 32'(bif.req_overwrite), 0);
        set_cmd(0, 1'b0, 2'd2, 2'b11);
        @(negedge clk);
        bif.send_req = '0;
        check("simul_grant_old", 32'(bif.send_grant), 32'b0001);
        check("simul_instr_old", 32'(bif.bus_instr), 2);
        check("simul_dst_old", 32'(bif.bus_dst_id), 1);
        check("simul_no_ovw", 32'(bif.req_overwrite), 0);
        check("simul_busy", 32'(bif.busy), 1);
        bif.bus_ready = 1'b1;
        @(negedge clk);
        check("simul_hs", 32'(bif.bus_valid), 0);
        @(negedge clk);
        check("simul_grant_new", 32'(bif.send_grant), 32'b0001);
        check("simul_instr_new", 32'(bif.bus_instr), 3);
        check("simul_dst_new", 32'(bif.bus_dst_id), 2);
        @(negedge clk);
        check("simul_end_busy", 32'(bif.busy), 0);

        // Asynchronous reset in the middle of a transfer
        do_reset();
        set_cmd(2, 1'b1, 2'd3, 2'b01);
        bif.send_req = 4'b0100;
        @(negedge clk);
        bif.send_req = '0;
        @(negedge clk);
        check("mid_pre_grant", 32'(bif.send_grant), 32'b0100);
        check("mid_pre_valid", 32'(bif.bus_valid), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bif.bus_valid), 0);
        check("mid_rst_grant", 32'(bif.send_grant), 0);
        check("mid_rst_busy", 32'(bif.busy), 0);
        @(negedge clk);
        resetn        = 1'b1;
        bif.bus_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("mid_after_valid%0d", c), 32'(bif.bus_valid), 0);
            check($sformatf("mid_after_grant%0d", c), 32'(bif.send_grant), 0);
        end

`ifdef ARB_TIMEOUT_EN
        // Timeout after 8 stalled XFER cycles, then next pending core wins
        do_reset();
        set_cmd(0, 1'b0, 2'd1, 2'b01);
        set_cmd(1, 1'b0, 2'd2, 2'b10);
        bif.send_req = 4'b0011;
        @(negedge clk);
        bif.send_req = '0;
        @(negedge clk);
        check("tmo_grant0", 32'(bif.send_grant), 32'b0001);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("tmo_wait_pulse%0d", c), 32'(bif.bus_timeout), 0);
            check($sformatf("tmo_wait_valid%0d", c), 32'(bif.bus_valid), 1);
        end
        @(negedge clk);
        check("tmo_pulse", 32'(bif.bus_timeout), 1);
        check("tmo_valid_drop", 32'(bif.bus_valid), 0);
        @(negedge clk);
        check("tmo_pulse_end", 32'(bif.bus_timeout), 0);
        check("tmo_next_grant", 32'(bif.send_grant), 32'b0010);
`else
        check("tmo_tied_low", 32'(bif.bus_timeout), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
